// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS-subset control unit: 12-state Moore FSM that sequences the
// ALU, memory and register-file controls and resolves beq from the ALU zero flag.
module multi_ctrl (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  input  logic       i_zf,
  output logic [2:0] o_aluc,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_pcsrc,
  output logic       o_pcwrite,
  output logic       o_iord,
  output logic       o_memwrite,
  output logic       o_irwrite,
  output logic       o_regwrite,
  output logic       o_regdst,
  output logic       o_memtoreg,
  output logic [3:0] o_state,
  output logic       o_done
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2, MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTEXE  = 4'd6, RTWB   = 4'd7,
    BRANCH  = 4'd8,  ADDIEXE = 4'd9,  ADDIWB = 4'd10, JUMP  = 4'd11
  } state_t;

  typedef struct packed {
    logic [2:0] aluc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       done;
  } ctl_t;

  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  function automatic logic [2:0] rt_aluc(input logic [5:0] f);
    case (f)
      6'b100000: rt_aluc = 3'b010;
      6'b100010: rt_aluc = 3'b110;
      6'b100100: rt_aluc = 3'b000;
      6'b100101: rt_aluc = 3'b001;
      6'b101010: rt_aluc = 3'b111;
      default:   rt_aluc = 3'b000;
    endcase
  endfunction

  function automatic ctl_t decode(input state_t s, input logic [5:0] f);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.irwrite = 1'b1; c.alusrcb = 2'b01; c.aluc = 3'b010; c.pcwrite = 1'b1; end
      DECODE:  begin c.alusrcb = 2'b11; c.aluc = 3'b010; end
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluc = 3'b010; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; c.done = 1'b1; end
      RTEXE:   begin c.alusrca = 1'b1; c.aluc = rt_aluc(f); end
      RTWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
      BRANCH:  begin c.alusrca = 1'b1; c.aluc = 3'b110; c.pcsrc = 2'b01; c.done = 1'b1; end
      ADDIEXE: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluc = 3'b010; end
      ADDIWB:  begin c.regwrite = 1'b1; c.done = 1'b1; end
      JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.done = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state, state_nxt;
  ctl_t   ctl;
  logic   rt_ok;

  assign rt_ok = (i_op == OP_RT) &&
                 (i_func == 6'b100000 || i_func == 6'b100010 || i_func == 6'b100100 ||
                  i_func == 6'b100101 || i_func == 6'b101010);

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:   state_nxt = DECODE;
      DECODE: begin
        if (i_op == OP_LW || i_op == OP_SW) state_nxt = MEMADR;
        else if (rt_ok)                     state_nxt = RTEXE;
        else if (i_op == OP_BEQ)            state_nxt = BRANCH;
        else if (i_op == OP_ADDI)           state_nxt = ADDIEXE;
        else if (i_op == OP_J)              state_nxt = JUMP;
        else                                state_nxt = FETCH;
      end
      MEMADR:  state_nxt = (i_op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_nxt = MEMWB;
      RTEXE:   state_nxt = RTWB;
      ADDIEXE: state_nxt = ADDIWB;
      default: state_nxt = FETCH;
    endcase
  end

  // Controls are registered alongside the state, decoded from the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= FETCH;
      ctl   <= decode(FETCH, i_func);
    end else begin
      state <= state_nxt;
      ctl   <= decode(state_nxt, i_func);
    end
  end

  // Write enables are killed combinationally so a reset aborts the current cycle's writes.
  assign o_pcwrite  = ~i_rst & (ctl.pcwrite | ((state == BRANCH) & i_zf));
  assign o_irwrite  = ~i_rst & ctl.irwrite;
  assign o_memwrite = ~i_rst & ctl.memwrite;
  assign o_regwrite = ~i_rst & ctl.regwrite;

  assign o_aluc     = ctl.aluc;
  assign o_alusrca  = ctl.alusrca;
  assign o_alusrcb  = ctl.alusrcb;
  assign o_pcsrc    = ctl.pcsrc;
  assign o_iord     = ctl.iord;
  assign o_regdst   = ctl.regdst;
  assign o_memtoreg = ctl.memtoreg;
  assign o_done     = ctl.done;
  assign o_state    = state;

endmodule

// File: tb/tb_multi_ctrl.sv
// Randomized scoreboard bench for multi_ctrl: per-instruction expected cycle records
// are queued by the driver and checked by an independent negedge monitor.
module tb_multi_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0, func = '0;
  logic       zf = 1'b0;
  logic [2:0] aluc;
  logic       alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcwrite, iord, memwrite, irwrite, regwrite, regdst, memtoreg, done;
  logic [3:0] state;

  multi_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_func(func), .i_zf(zf),
    .o_aluc(aluc), .o_alusrca(alusrca), .o_alusrcb(alusrcb), .o_pcsrc(pcsrc),
    .o_pcwrite(pcwrite), .o_iord(iord), .o_memwrite(memwrite), .o_irwrite(irwrite),
    .o_regwrite(regwrite), .o_regdst(regdst), .o_memtoreg(memtoreg),
    .o_state(state), .o_done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aluc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcw, iord, memw, irw, regw, regdst, m2r, done;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  bit   stim_done = 0;

  // Instruction -> sequence of states visited, straight from the transition rules.
  function automatic int path_len(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000100: return 3;
      6'b001000: return 4;
      6'b000010: return 3;
      6'b000000: return (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) ? 4 : 2;
      default:   return 2;
    endcase
  endfunction

  function automatic logic [3:0] path_state(input logic [5:0] o, input int i);
    if (i == 0) return 4'd0;
    if (i == 1) return 4'd1;
    case (o)
      6'b100011: return (i == 2) ? 4'd2 : (i == 3) ? 4'd3 : 4'd4;
      6'b101011: return (i == 2) ? 4'd2 : 4'd5;
      6'b000100: return 4'd8;
      6'b001000: return (i == 2) ? 4'd9 : 4'd10;
      6'b000010: return 4'd11;
      default:   return (i == 2) ? 4'd6 : 4'd7;
    endcase
  endfunction

  function automatic rec_t model_out(input logic [3:0] s, input logic [5:0] f, input logic z);
    rec_t r;
    r = '0;
    r.st = s;
    case (s)
      4'd0:  begin r.irw = 1; r.srcb = 2'b01; r.aluc = 3'b010; r.pcw = 1; end
      4'd1:  begin r.srcb = 2'b11; r.aluc = 3'b010; end
      4'd2:  begin r.srca = 1; r.srcb = 2'b10; r.aluc = 3'b010; end
      4'd3:  r.iord = 1;
      4'd4:  begin r.m2r = 1; r.regw = 1; r.done = 1; end
      4'd5:  begin r.iord = 1; r.memw = 1; r.done = 1; end
      4'd6:  begin
        r.srca = 1;
        r.aluc = (f == 6'b100000) ? 3'b010 : (f == 6'b100010) ? 3'b110 :
                 (f == 6'b100100) ? 3'b000 : (f == 6'b100101) ? 3'b001 : 3'b111;
      end
      4'd7:  begin r.regdst = 1; r.regw = 1; r.done = 1; end
      4'd8:  begin r.srca = 1; r.aluc = 3'b110; r.pcsrc = 2'b01; r.pcw = z; r.done = 1; end
      4'd9:  begin r.srca = 1; r.srcb = 2'b10; r.aluc = 3'b010; end
      4'd10: begin r.regw = 1; r.done = 1; end
      4'd11: begin r.pcsrc = 2'b10; r.pcw = 1; r.done = 1; end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic rec_t kill_we(input rec_t r);
    rec_t k;
    k = r;
    k.pcw = 0; k.irw = 0; k.memw = 0; k.regw = 0;
    return k;
  endfunction

  // Starts in a FETCH cycle, just after the edge. rst_at<0 means no reset;
  // otherwise reset is raised in that cycle of the instruction for rst_len cycles.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int rst_at, input int rst_len);
    int n, total, plen;
    bit hit;
    plen = path_len(o, f);
    hit  = (rst_at >= 0) && (rst_at < plen);
    n    = hit ? rst_at + 1 : plen;
    for (int i = 0; i < n; i++) begin
      rec_t e;
      e = model_out(path_state(o, i), f, z);
      if (hit && i == rst_at) e = kill_we(e);
      exp_q.push_back(e);
    end
    total = n;
    if (hit) begin
      for (int j = 1; j < rst_len; j++) begin
        exp_q.push_back(kill_we(model_out(4'd0, f, z)));
        total++;
      end
    end
    op = o; func = f; zf = z;
    for (int c = 0; c < total; c++) begin
      rst = hit && (c >= rst_at);
      @(posedge clk); #1;
    end
    rst = 0;
  endtask

  // Monitor: one expected record per cycle while anything is queued.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        rec_t e, a;
        e = exp_q.pop_front();
        a = '{st: state, aluc: aluc, srca: alusrca, srcb: alusrcb, pcsrc: pcsrc,
              pcw: pcwrite, iord: iord, memw: memwrite, irw: irwrite, regw: regwrite,
              regdst: regdst, m2r: memtoreg, done: done};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL ctrl cyc=%0d op=%b func=%b zf=%b rst=%b: got %h want %h (st %0d/%0d)",
                   cyc, op, func, zf, rst, a, e, a.st, e.st);
        end
      end
    end
  end

  logic [5:0] rt_funcs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [5:0] ops      [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};

  initial begin
    rst = 1;
    @(posedge clk); #1;
    exp_q.push_back(kill_we(model_out(4'd0, func, zf)));
    @(posedge clk); #1;
    rst = 0;

    run_instr(6'b100011, 6'b000000, 1'b0, -1, 1);
    for (int i = 0; i < 5; i++) run_instr(6'b000000, rt_funcs[i], 1'b0, -1, 1);
    run_instr(6'b000100, 6'b000000, 1'b1, -1, 1);
    run_instr(6'b000100, 6'b000000, 1'b0, -1, 1);
    run_instr(6'b111111, 6'b000000, 1'b0, -1, 1);
    run_instr(6'b000000, 6'b000000, 1'b0, -1, 1);
    run_instr(6'b101011, 6'b000000, 1'b0, 3, 1);
    run_instr(6'b001000, 6'b000000, 1'b0, -1, 1);
    run_instr(6'b000010, 6'b000000, 1'b0, -1, 1);
    run_instr(6'b100011, 6'b000000, 1'b0, 2, 2);
    run_instr(6'b000000, 6'b100101, 1'b1, 3, 2);

    for (int k = 0; k < 300; k++) begin
      logic [5:0] o, f;
      int ra, rl;
      o  = ops[$urandom_range(0, 6)];
      if (o == 6'b111111) o = 6'($urandom);
      f  = ($urandom_range(0, 3) != 0) ? rt_funcs[$urandom_range(0, 4)] : 6'($urandom);
      ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
      rl = $urandom_range(1, 2);
      run_instr(o, f, 1'($urandom), ra, rl);
    end
    stim_done = 1;
  end

  initial begin
    int guard;
    guard = 0;
    while (!stim_done && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    n_cmp++;
    if (!stim_done || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: stim_done=%0d pending=%0d want 1/0", stim_done, exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_ctrl.md
# multi_ctrl

Multi-cycle control unit for the MIPS-subset datapath. It sits directly upstream of the ALU: it decodes the instruction register's opcode and function fields and sequences a 12-state Moore FSM. Each state drives the ALU control code, the ALU operand selects and the PC/IR/memory/register-file enables. The ALU's zero flag returns to this block to resolve `beq`.

## Interface
Parameters: none.

- `i_clk` in 1: single clock; all state changes on the rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_op` in 6: `IR[31:26]`, the opcode field.
- `i_func` in 6: `IR[5:0]`, the R-type function field.
- `i_zf` in 1: ALU zero flag.
- `o_aluc` out 3: ALU control code.
  - `000` AND, `001` OR, `010` ADD, `110` SUB (sets the zero flag), `111` SLT.
- `o_alusrca` out 1: selects ALU operand r.
  - 0 = PC, 1 = register A.
- `o_alusrcb` out 2: selects ALU operand s.
  - `00` = register B, `01` = constant 4, `10` = sign-extended immediate, `11` = sign-extended immediate shifted left by 2.
- `o_pcsrc` out 2: selects the next PC.
  - `00` = ALU result, `01` = ALUOut, `10` = jump target.
- `o_pcwrite` out 1: PC write enable.
- `o_iord` out 1: memory address select.
  - 0 = PC, 1 = ALUOut.
- `o_memwrite` out 1: memory write enable.
- `o_irwrite` out 1: instruction register write enable.
- `o_regwrite` out 1: register file write enable.
- `o_regdst` out 1: destination register select.
  - 0 = rt, 1 = rd.
- `o_memtoreg` out 1: write-back data select.
  - 0 = ALUOut, 1 = MDR.
- `o_state` out 4: current state encoding, for debug and verification.
- `o_done` out 1: high in the last cycle of every instruction.

## Operation
- State encoding:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR.
  - 6 RTEXE, 7 RTWB, 8 BRANCH, 9 ADDIEXE, 10 ADDIWB, 11 JUMP.
  - Codes 12–15 are unreachable; if entered, the next state is FETCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR for `lw` (`100011`) or `sw` (`101011`).
  - DECODE → RTEXE for opcode `000000` with a supported function: add `100000`, sub `100010`, and `100100`, or `100101`, slt `101010`.
  - DECODE → BRANCH for `beq` (`000100`).
  - DECODE → ADDIEXE for `addi` (`001000`).
  - DECODE → JUMP for `j` (`000010`).
  - DECODE → FETCH for any other opcode or function (illegal instruction, treated as a no-op).
  - MEMADR → MEMRD for `lw`, MEMADR → MEMWR for `sw`.
  - MEMRD → MEMWB; RTEXE → RTWB; ADDIEXE → ADDIWB.
  - MEMWB, MEMWR, RTWB, BRANCH, ADDIWB and JUMP → FETCH.
- Outputs are decoded from the state only (Moore), except `o_pcwrite` in BRANCH.
- Any output not listed for a state is 0; `o_aluc` is `000` unless listed.
  - FETCH: `irwrite=1`, `alusrca=0`, `alusrcb=01`, `aluc=010`, `pcsrc=00`, `pcwrite=1`.
  - DECODE: `alusrca=0`, `alusrcb=11`, `aluc=010` (computes the branch target).
  - MEMADR: `alusrca=1`, `alusrcb=10`, `aluc=010`.
  - MEMRD: `iord=1`.
  - MEMWB: `regdst=0`, `memtoreg=1`, `regwrite=1`.
  - MEMWR: `iord=1`, `memwrite=1`.
  - RTEXE: `alusrca=1`, `alusrcb=00`, `aluc` from `i_func`:
    - add → `010`, sub → `110`, and → `000`, or → `001`, slt → `111`.
  - RTWB: `regdst=1`, `regwrite=1`.
  - BRANCH: `alusrca=1`, `alusrcb=00`, `aluc=110`, `pcsrc=01`, `pcwrite=i_zf` (combinational pass-through of the zero flag).
  - ADDIEXE: `alusrca=1`, `alusrcb=10`, `aluc=010`.
  - ADDIWB: `regwrite=1`.
  - JUMP: `pcsrc=10`, `pcwrite=1`.
- `o_done=1` in MEMWB, MEMWR, RTWB, BRANCH, ADDIWB and JUMP.
- `i_op` and `i_func` are sampled whenever they are used. The datapath holds the IR stable from DECODE until the next FETCH.

## Timing
- Reset:
  - While `i_rst=1`: `o_pcwrite`, `o_irwrite`, `o_memwrite` and `o_regwrite` are forced to 0 combinationally. All other outputs follow the current state.
  - On the first rising edge with `i_rst=1`, the state becomes FETCH (`o_state=0`).
  - After release, the first cycle is FETCH with its full enables.
- Reset mid-instruction: the instruction is abandoned. No write enable is asserted from the cycle reset is seen onward, and no partial write-back occurs after that edge.
- Latency in cycles, from FETCH through the `o_done` cycle:
  - `lw` 5; `sw`, R-type and `addi` 4; `beq` and `j` 3.
  - Illegal instruction: 2 cycles, with no `o_done`.
- `o_done` is a one-cycle pulse. The next cycle is always FETCH.
- BRANCH: the PC updates on the edge ending BRANCH only if `i_zf=1` during that cycle.
  - A glitch-free `i_zf` is the datapath's responsibility.

## Test plan
- Reset check: hold `i_rst` for 2 cycles in an arbitrary state, then release.
  - During reset: `o_state=0` and all write enables are 0.
  - First cycle after release: `o_irwrite=1`, `o_pcwrite=1`, `o_aluc=010`.
- `lw`: `i_op=100011`.
  - Required state sequence: 0, 1, 2, 3, 4, 0.
  - MEMRD: `o_iord=1`. MEMWB: `o_memtoreg=1`, `o_regwrite=1`, `o_regdst=0`, `o_done=1`.
- R-type sweep: `i_op=0` with `i_func` = `100000`, `100010`, `100100`, `100101`, `101010` in turn.
  - RTEXE `o_aluc` must be `010`, `110`, `000`, `001`, `111` respectively.
  - RTWB: `o_regdst=1`, `o_regwrite=1`.
- `beq`: `i_op=000100`, run once with `i_zf=1` and once with `i_zf=0`.
  - State sequence 0, 1, 8, 0. In state 8: `o_aluc=110`, `o_pcsrc=01`.
  - `o_pcwrite` is 1 for `i_zf=1` and 0 for `i_zf=0`.
- Illegal instructions: `i_op=111111`, then `i_op=0` with `i_func=000000`.
  - Each goes 0, 1, 0 with no write enable or `o_done` asserted in state 1.
- Reset in MEMWR during `sw`: assert `i_rst` in state 5.
  - `o_memwrite` drops to 0 in that same cycle; the next state is 0.
